// File: rtl/router_rr_scheduler.sv
// Purpose : round-robin scheduler feeding one 1-to-4 address-routed datapath
//           from NUM_REQ valid/ready requesters through a one-entry output slot.
// Latency : a word accepted at edge N is on din/addr/din_en after edge N.
// Backpr. : the slot holds until dst_ready[addr]; while it holds, req_ready is 0.
//           A drain and a new grant can happen on the same edge (1 word/cycle).
//
// Ports:
//   clk, resetn             rising-edge clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready is one-hot)
//   req_data, req_addr      packed per-requester word and 2-bit destination
//   dst_ready               per-destination ready from the router outputs
//   din, din_en, addr       registered slot contents driven to the router
//   rr_ptr                  current highest-priority requester (debug)
module router_rr_scheduler #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3:0]                    dst_ready,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          din_en,
  output logic [1:0]                    addr,
  output logic [PTR_W-1:0]              rr_ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state;
  logic                    drain;
  logic                    open;
  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        idx;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        nxt_ptr;
  logic                    found;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [1:0]              sel_addr;

  // Only the addressed destination's ready matters.
  assign drain = (state == FULL) && dst_ready[addr];
  assign open  = (state == EMPTY) || drain;

  // Rotating search from rr_ptr, wrapping at NUM_REQ (which need not be a
  // power of two, so the wrap is explicit rather than modular overflow).
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = rr_ptr;
    if (open) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[idx]) begin
          found        = 1'b1;
          grant[idx]   = 1'b1;
          win_idx      = idx;
        end
        idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  assign nxt_ptr = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);

  // The state registers already sit in reset, which alone would open the
  // accept window; gate grants so no requester sees an acceptance in reset.
  assign req_ready = grant & {NUM_REQ{resetn}};

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_addr = req_addr[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= EMPTY;
      din    <= '0;
      addr   <= '0;
      rr_ptr <= '0;
    end else if (found) begin
      // Covers both an empty slot and drain+reload in the same cycle.
      state  <= FULL;
      din    <= sel_data;
      addr   <= sel_addr;
      rr_ptr <= nxt_ptr;
    end else if (drain) begin
      state  <= EMPTY;
      din    <= '0;
      addr   <= '0;
    end
  end

  assign din_en = (state == FULL);

endmodule

// File: tb/tb_router_rr_scheduler.sv
module tb_router_rr_scheduler;

  localparam int DW = 32;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR*2-1:0]   req_addr;
  logic [NR-1:0]     req_ready;
  logic [3:0]        dst_ready;
  logic [DW-1:0]     din;
  logic              din_en;
  logic [1:0]        addr;
  logic [1:0]        rr_ptr;

  router_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .dst_ready (dst_ready),
    .din       (din),
    .din_en    (din_en),
    .addr      (addr),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    a;
  } ent_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  ent_t          sbq[$];
  bit            m_full  = 1'b0;
  int            m_ptr   = 0;
  bit            consume = 1'b0;
  logic [NR-1:0] exp_gnt;
  int            gnt_idx;
  bit            m_drain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected grant from the model's slot state and pointer.
  task automatic model_eval();
    exp_gnt = '0;
    gnt_idx = -1;
    m_drain = 1'b0;
    if (m_full) m_drain = dst_ready[sbq[0].a];
    if (resetn && (!m_full || m_drain)) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (gnt_idx < 0 && req_valid[i]) begin
          gnt_idx    = i;
          exp_gnt[i] = 1'b1;
        end
      end
    end
  endtask

  // Check at negedge, advance the model at posedge, change inputs just after.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("req_ready", 64'(req_ready), 64'(exp_gnt));
    chk("din_en", 64'(din_en), 64'(m_full));
    chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    if (m_full) begin
      chk("din", 64'(din), 64'(sbq[0].d));
      chk("addr", 64'(addr), 64'(sbq[0].a));
    end else begin
      chk("din_empty", 64'(din), 64'd0);
      chk("addr_empty", 64'(addr), 64'd0);
    end
    @(posedge clk);
    if (!resetn) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sbq.delete();
    end else begin
      if (m_drain) void'(sbq.pop_front());
      if (gnt_idx >= 0) begin
        sbq.push_back('{d: req_data[gnt_idx*DW +: DW], a: req_addr[gnt_idx*2 +: 2]});
        m_ptr  = (gnt_idx + 1) % NR;
        m_full = 1'b1;
      end else if (m_drain) begin
        m_full = 1'b0;
      end
    end
    #1;
    if (resetn && gnt_idx >= 0) begin
      if (consume) req_valid[gnt_idx] = 1'b0;
      else         req_data[gnt_idx*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    dst_ready = 4'b0001;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h1000_0000 + i;

    // Reset held with all requesters valid: nothing granted, slot empty.
    repeat (3) cycle();
    resetn = 1'b1;

    // Round-robin: all valid, all to dest 0 which is always ready.
    consume = 1'b0;
    repeat (10) cycle();

    // Single request to dest 3.
    req_valid = '0;
    dst_ready = 4'b1111;
    repeat (2) cycle();
    consume = 1'b1;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_addr[2*2 +: 2]   = 2'b11;
    req_valid            = 4'b0100;
    dst_ready            = 4'b1000;
    repeat (3) cycle();

    // Backpressure: word for dest 1 stalls while others are valid.
    req_addr[1*2 +: 2] = 2'b01;
    req_valid          = 4'b0010;
    dst_ready          = 4'b1101;
    cycle();
    consume   = 1'b0;
    req_valid = 4'b1111;
    repeat (5) cycle();
    dst_ready = 4'b1111;
    repeat (2) cycle();

    // Skip idle: pointer past req 0, only req 0 valid -> wrap search.
    consume   = 1'b1;
    req_valid = '0;
    repeat (2) cycle();
    req_valid = 4'b0001;
    repeat (2) cycle();
    req_valid = 4'b0001;
    repeat (2) cycle();

    // Asynchronous reset mid-transfer with the slot stalled on dest 2.
    req_addr[2*2 +: 2] = 2'b10;
    req_valid          = 4'b0100;
    dst_ready          = 4'b0000;
    repeat (2) cycle();
    req_valid = 4'b1111;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_din_en", 64'(din_en), 64'd0);
    chk("async_din", 64'(din), 64'd0);
    chk("async_req_ready", 64'(req_ready), 64'd0);
    chk("async_rr_ptr", 64'(rr_ptr), 64'd0);
    m_full = 1'b0;
    m_ptr  = 0;
    sbq.delete();
    cycle();
    resetn    = 1'b1;
    dst_ready = 4'b1111;
    consume   = 1'b0;
    repeat (3) cycle();

    // Random traffic; requesters hold their word until accepted.
    consume   = 1'b1;
    req_valid = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          req_data[i*DW +: DW] = $urandom;
          req_addr[i*2 +: 2]   = 2'($urandom_range(0, 3));
          req_valid[i]         = 1'b1;
        end
      end
      dst_ready = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
